// File: rtl/cache_array_pkg.sv
// cache_array_pkg
//   Shared types and helpers for the multi-way cache data array.
//   - array_state_t : controller phase (CLEAR after reset, then RUN)
//   - byte_merge    : one byte lane of a masked line update; the storage
//                     write path and the same-cycle read bypass both use it
//                     so the two can never disagree on merge semantics.
package cache_array_pkg;

    typedef enum logic {CLEAR, RUN} array_state_t;

    // Returns new_byte where the strobe is set, otherwise old_byte.
    function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                              input logic [7:0] new_byte,
                                              input logic       mask);
        return mask ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/data_array_bank.sv
// data_array_bank
//   Storage for one way: 2**s_index lines of s_line bits.
//   Ports:
//     clk          clock
//     clear        write zero to clear_index this cycle (wins over write)
//     clear_index  set being cleared
//     we           write request (already qualified by way select)
//     byte_en      per-byte write strobes
//     write_index  set to write
//     datain       write data
//     read_index   set to read
//     dataout      combinational read of read_index
module data_array_bank
    import cache_array_pkg::*;
#(
    parameter int s_index = 3,
    parameter int s_mask  = 32,
    parameter int s_line  = 8 * s_mask
) (
    input  logic               clk,
    input  logic               clear,
    input  logic [s_index-1:0] clear_index,
    input  logic               we,
    input  logic [s_mask-1:0]  byte_en,
    input  logic [s_index-1:0] write_index,
    input  logic [s_line-1:0]  datain,
    input  logic [s_index-1:0] read_index,
    output logic [s_line-1:0]  dataout
);

    // No reset on the storage: contents are defined only by the clear sweep.
    logic [s_line-1:0] mem [2**s_index];
    logic [s_line-1:0] merged;

    always_comb begin
        merged = mem[write_index];
        for (int i = 0; i < s_mask; i++) begin
            merged[8*i +: 8] = byte_merge(mem[write_index][8*i +: 8],
                                          datain[8*i +: 8], byte_en[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            mem[clear_index] <= '0;
        end else if (we) begin
            mem[write_index] <= merged;
        end
    end

    assign dataout = mem[read_index];

endmodule

// File: rtl/multiway_data_array.sv
// multiway_data_array
//   N-way cache data array: per-byte write strobes, registered read data,
//   write-first bypass for a same-cycle read of the line being written, and
//   a hardware clear sweep of every set after reset.
//   Ports:
//     clk, rst       clock; synchronous active-high reset
//     ready          high once the clear sweep has finished (RUN)
//     read           read request; read_index/read_way select the line
//     write_en       per-byte write strobes; write_index/write_way select line
//     datain         write data
//     dataout        registered read data (holds when no read is accepted)
//     dataout_valid  high the cycle after an accepted read
module multiway_data_array
    import cache_array_pkg::*;
#(
    parameter int s_offset = 5,
    parameter int s_index  = 3,
    parameter int num_ways = 2,
    parameter int s_mask   = 2**s_offset,
    parameter int s_line   = 8 * s_mask,
    parameter int s_way    = (num_ways > 1) ? $clog2(num_ways) : 1
) (
    input  logic               clk,
    input  logic               rst,
    output logic               ready,
    input  logic               read,
    input  logic [s_index-1:0] read_index,
    input  logic [s_way-1:0]   read_way,
    input  logic [s_mask-1:0]  write_en,
    input  logic [s_index-1:0] write_index,
    input  logic [s_way-1:0]   write_way,
    input  logic [s_line-1:0]  datain,
    output logic [s_line-1:0]  dataout,
    output logic               dataout_valid
);

    array_state_t       state, state_nxt;
    logic [s_index-1:0] clr_idx, clr_idx_nxt;

    logic [num_ways-1:0]             bank_we;
    logic [num_ways-1:0][s_line-1:0] bank_rdata;
    logic                            wr_fire;
    logic                            rd_hit;
    logic [s_line-1:0]               rd_line;

    // ------------------------------------------------------------------
    // Controller FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        case (state)
            CLEAR: begin
                clr_idx_nxt = clr_idx + 1'b1;
                // Last set is zeroed on this edge, so RUN starts next cycle.
                if (clr_idx == {s_index{1'b1}}) state_nxt = RUN;
            end
            RUN: ;
            default: state_nxt = CLEAR;
        endcase
    end

    assign ready = (state == RUN);

    // ------------------------------------------------------------------
    // Way banks
    // ------------------------------------------------------------------
    assign wr_fire = ready && (|write_en);

    // Out-of-range way selects match no bank: writes drop, reads see zero.
    always_comb begin
        bank_we = '0;
        for (int w = 0; w < num_ways; w++) begin
            bank_we[w] = wr_fire && (write_way == s_way'(w));
        end
    end

    for (genvar gw = 0; gw < num_ways; gw++) begin : g_way
        data_array_bank #(
            .s_index (s_index),
            .s_mask  (s_mask),
            .s_line  (s_line)
        ) u_bank (
            .clk         (clk),
            .clear       (state == CLEAR),
            .clear_index (clr_idx),
            .we          (bank_we[gw]),
            .byte_en     (write_en),
            .write_index (write_index),
            .datain      (datain),
            .read_index  (read_index),
            .dataout     (bank_rdata[gw])
        );
    end

    // ------------------------------------------------------------------
    // Read way mux plus write-first bypass
    // ------------------------------------------------------------------
    always_comb begin
        rd_line = '0;
        rd_hit  = 1'b0;
        for (int w = 0; w < num_ways; w++) begin
            if (read_way == s_way'(w)) begin
                rd_line = bank_rdata[w];
                rd_hit  = 1'b1;
            end
        end
        // Storage updates only at the edge, so patch the strobed bytes in
        // here to return the post-write line.
        if (rd_hit && wr_fire && (write_way == read_way) &&
            (write_index == read_index)) begin
            for (int i = 0; i < s_mask; i++) begin
                rd_line[8*i +: 8] = byte_merge(rd_line[8*i +: 8],
                                               datain[8*i +: 8], write_en[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dataout       <= '0;
            dataout_valid <= 1'b0;
        end else if (ready && read) begin
            dataout       <= rd_line;
            dataout_valid <= 1'b1;
        end else begin
            dataout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multiway_data_array.sv
module tb_multiway_data_array;

    localparam int NW   = 2;
    localparam int NS   = 8;
    localparam int LINE = 256;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ready;
    logic             read = 1'b0;
    logic [2:0]       read_index = '0;
    logic [0:0]       read_way = '0;
    logic [31:0]      write_en = '0;
    logic [2:0]       write_index = '0;
    logic [0:0]       write_way = '0;
    logic [LINE-1:0]  datain = '0;
    logic [LINE-1:0]  dataout;
    logic             dataout_valid;

    multiway_data_array dut (
        .clk           (clk),
        .rst           (rst),
        .ready         (ready),
        .read          (read),
        .read_index    (read_index),
        .read_way      (read_way),
        .write_en      (write_en),
        .write_index   (write_index),
        .write_way     (write_way),
        .datain        (datain),
        .dataout       (dataout),
        .dataout_valid (dataout_valid)
    );

    always #5 clk = ~clk;

    // Illegal way selects must never be issued by this bench.
    always @(negedge clk) begin
        if (!rst && ready) begin
            assert (!read || int'(read_way) < NW)
                else $error("read_way out of range: %0d", read_way);
            assert (write_en == 0 || int'(write_way) < NW)
                else $error("write_way out of range: %0d", write_way);
        end
    end

    // Reference model: contents of every line, plus the expected output reg.
    logic [LINE-1:0] mdl [NW][NS];
    logic [LINE-1:0] exp_dout;
    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [LINE-1:0] got,
                       input logic [LINE-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [LINE-1:0] rnd_line();
        logic [LINE-1:0] r;
        for (int i = 0; i < LINE / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic mdl_clear();
        for (int w = 0; w < NW; w++)
            for (int s = 0; s < NS; s++) mdl[w][s] = '0;
        exp_dout = '0;
    endtask

    // One clock with the given request. Model is write-first: the write is
    // applied to the model before the read looks it up.
    task automatic step(input logic rd, input int ri, input int rw,
                        input logic [31:0] we, input int wi, input int ww,
                        input logic [LINE-1:0] din, input string tag);
        logic rdy;
        logic exp_v;
        read = rd; read_index = 3'(ri); read_way = 1'(rw);
        write_en = we; write_index = 3'(wi); write_way = 1'(ww); datain = din;
        rdy   = ready;
        exp_v = 1'b0;
        if (rdy) begin
            for (int b = 0; b < 32; b++)
                if (we[b]) mdl[ww][wi][8*b +: 8] = din[8*b +: 8];
            if (rd) begin
                exp_dout = mdl[rw][ri];
                exp_v    = 1'b1;
            end
        end
        @(posedge clk); #1;
        chk({tag, "_valid"}, LINE'(dataout_valid), LINE'(exp_v));
        chk({tag, "_dout"}, dataout, exp_dout);
        read = 1'b0; write_en = '0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_rst_ready"}, LINE'(ready), '0);
        chk({tag, "_rst_valid"}, LINE'(dataout_valid), '0);
        chk({tag, "_rst_dout"}, dataout, '0);
        rst = 1'b0;
        mdl_clear();
    endtask

    // Counts clear cycles while firing random requests that must be ignored.
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!ready && n < 20) begin
            step(1'b1, $urandom_range(0, 7), $urandom_range(0, 1), $urandom,
                 $urandom_range(0, 7), $urandom_range(0, 1), rnd_line(), tag);
            n++;
        end
        chk({tag, "_clear_len"}, LINE'(n), LINE'(8));
    endtask

    task automatic read_all(input string tag);
        for (int w = 0; w < NW; w++)
            for (int s = 0; s < NS; s++) begin
                step(1'b1, s, w, '0, 0, 0, '0, tag);
                chk({tag, "_zero"}, dataout, '0);
            end
    endtask

    initial begin
        logic [LINE-1:0] snap;
        logic [LINE-1:0] old_w1;

        // Reset and first clear, then fill with garbage and clear again.
        do_reset("init");
        wait_ready("init");
        for (int w = 0; w < NW; w++)
            for (int s = 0; s < NS; s++)
                step(1'b0, 0, 0, '1, s, w, rnd_line(), "fill");
        do_reset("reclr");
        wait_ready("reclr");
        read_all("after_clr");

        // Byte-masked write.
        step(1'b0, 0, 0, 32'h0000_000F, 3, 1, {32{8'hAA}}, "bm_wr");
        step(1'b1, 3, 1, '0, 0, 0, '0, "bm_rd");
        chk("bm_bytes", dataout, {224'h0, 32'hAAAA_AAAA});
        step(1'b1, 3, 0, '0, 0, 0, '0, "bm_other_way");
        chk("bm_way0", dataout, '0);

        // Write-first bypass.
        step(1'b0, 0, 0, '1, 5, 0, {32{8'h11}}, "byp_pre");
        step(1'b1, 5, 0, 32'h1, 5, 0, {{31{8'h00}}, 8'h22}, "byp");
        chk("byp_line", dataout, {{31{8'h11}}, 8'h22});
        chk("byp_valid", LINE'(dataout_valid), LINE'(1));

        // Same index, different way in the same cycle.
        old_w1 = rnd_line();
        step(1'b0, 0, 0, '1, 2, 1, old_w1, "dw_pre");
        step(1'b1, 2, 1, '1, 2, 0, rnd_line(), "dw");
        chk("dw_old", dataout, old_w1);

        // Hold: one read, then idle cycles writing the same location.
        step(1'b1, 4, 1, '0, 0, 0, '0, "hold_rd");
        snap = dataout;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 0, 0, $urandom | 32'h1, 4, 1, rnd_line(), "hold_idle");
            chk("hold_dout", dataout, snap);
        end

        // Random traffic.
        for (int k = 0; k < 300; k++) begin
            logic [31:0] we;
            we = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            step($urandom_range(0, 1) == 1, $urandom_range(0, 7),
                 $urandom_range(0, 1), we, $urandom_range(0, 7),
                 $urandom_range(0, 1), rnd_line(), "rand");
        end

        // Reset during a RUN read.
        read = 1'b1; read_index = 3'd5; read_way = 1'b0;
        do_reset("run_rst");
        read = 1'b0;
        wait_ready("run_rst");
        read_all("run_rst");

        // Reset on the 4th clear cycle restarts the sweep.
        step(1'b0, 0, 0, '1, 1, 1, rnd_line(), "pre_mid");
        do_reset("mid1");
        for (int k = 0; k < 3; k++)
            step(1'b1, k, 1, '1, k, 1, rnd_line(), "mid_clear");
        do_reset("mid2");
        wait_ready("mid2");
        read_all("mid2");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/multiway_data_array.md
# multiway_data_array

Parametrised N-way cache data array with per-byte write enables, registered read output, and write-first same-cycle bypass. Successor to the single-way latched array used by the L1 caches. It also clears itself in hardware after reset, so the cache controller no longer relies on initial values. It sits under the cache datapath and is addressed by set index plus way select.

## Interface
- s_offset, 5, log2 of line size in bytes
- s_index, 3, log2 of set count
- num_ways, 2, associativity (1..8)
- s_mask, 2**s_offset, bytes per line (derived, do not override)
- s_line, 8*s_mask, bits per line (derived)
- s_way, $clog2(num_ways) (min 1), way-select width (derived)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ready  out  1  high when array accepts reads and writes
- read  in  1  read request
- read_index  in  s_index  set to read
- read_way  in  s_way  way to read
- write_en  in  s_mask  per-byte write strobes
- write_index  in  s_index  set to write
- write_way  in  s_way  way to write
- datain  in  s_line  write data
- dataout  out  s_line  registered read data
- dataout_valid  out  1  pulses the cycle after an accepted read

## Operation
- States: CLEAR, RUN.
- rst=1 sets the following on the next edge:
  - state=CLEAR, clr_idx=0, ready=0, dataout=0, dataout_valid=0.
  - Reset asserted mid-CLEAR or mid-RUN always restarts the clear from index 0.
- CLEAR:
  - Each cycle, writes 0 to set clr_idx in every way, then increments clr_idx.
  - When clr_idx==2**s_index-1 is written, moves to RUN on the same edge.
  - ready=0 for the whole phase.
  - read and write_en are ignored: no storage change, dataout_valid=0, dataout holds.
- RUN (ready=1):
  - Write: each byte i with write_en[i]=1 updates data[write_way][write_index][8i+:8]. Other bytes and ways keep their value.
  - A write with write_en=0 is a no-op.
  - Read (read=1): dataout is loaded with the line at [read_way][read_index]. dataout_valid=1 on the following cycle.
  - Without read: dataout holds its last value and dataout_valid=0.
  - Simultaneous read and write to the same index and way (write-first): dataout returns the stored line with the enabled bytes replaced by datain.
  - Same index, different way: no interaction; the read returns the old contents of the read way.
- Way select values >= num_ways are illegal. The implementation drops such writes and returns 0 for such reads. The bench flags them with an assertion.
- Storage has no initial value; correctness relies only on CLEAR.

## Timing
- Read latency: 1 cycle. Request at edge N is visible on dataout/dataout_valid after edge N+1.
- Write latency: 1 cycle. A read issued the cycle after a write sees the new data. A read in the same cycle sees it through the bypass.
- After rst deasserts, CLEAR lasts exactly 2**s_index cycles. ready rises after the last clear edge (8 cycles with default parameters).
- Back-to-back reads are supported every cycle; throughput is 1 read plus 1 write per cycle.
- dataout_valid is never high while ready=0 or in the cycle after reset.

## Structure
- cache_array_pkg holds:
  - typedef enum {CLEAR, RUN} array_state_t
  - function byte_merge(old, new, mask), used by both the write and bypass paths
- One sub-module: data_array_bank (one way). It has a write port with byte mask, clear input and combinational read. It is instantiated num_ways times under generate.
- multiway_data_array holds the FSM, clr_idx counter, output register, way mux and bypass.

## Test plan
- Reset clear:
  - Stimulus: preload garbage by forcing storage, then hold rst=1 for 1 cycle.
  - Required: ready=0 for exactly 8 cycles, then 1. Reading every set and way returns 0.
- Byte-masked write:
  - Stimulus: write way 1, index 3, write_en=0x0000000F, datain all 0xAA bytes. Then read way 1, index 3.
  - Required: bytes 0-3 are 0xAA, others 0. Way 0 index 3 is still 0.
- Write-first bypass:
  - Stimulus: way 0, index 5 holds 0x11 bytes. Same cycle: write_en=0x1 with datain byte0=0x22, and read way 0, index 5.
  - Required: next cycle dataout byte0=0x22, bytes 1-31=0x11, dataout_valid=1.
- Different-way same-cycle:
  - Stimulus: write way 0, index 2 and read way 1, index 2 in the same cycle.
  - Required: the read returns the old way-1 data.
- Reset mid-operation:
  - Stimulus: assert rst on the 4th CLEAR cycle, and separately during a RUN read.
  - Required: dataout=0 and dataout_valid=0 next cycle. ready stays 0 for 8 more cycles. Requests during CLEAR have no effect.
- Hold/no-read:
  - Stimulus: read once, then 5 idle cycles with writes to the same location.
  - Required: dataout is unchanged and dataout_valid=0 during the idle cycles.
